// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding logic.
// Scoreboard rd fields are held at a fixed width; narrower register addresses are zero-extended.
package pipe_pkg;

    localparam int SB_RD_W = 8;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic               v;
        logic               wr;
        logic [SB_RD_W-1:0] rd;
        logic               ld;
    } sb_entry_t;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Operand forwarding select: compares one ID source against the EX and MEM scoreboard entries.
// The youngest producer wins; a load in EX cannot forward, and register 0 never forwards.
module fwd_select
    import pipe_pkg::*;
(
    input  logic [SB_RD_W-1:0] src_i,
    input  sb_entry_t          e_i,
    input  sb_entry_t          m_i,
    output logic [1:0]         sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (src_i != '0) begin
            if (e_i.v && e_i.wr && !e_i.ld && (e_i.rd == src_i)) begin
                sel_o = FWD_EXMEM;
            end else if (m_i.v && m_i.wr && (m_i.rd == src_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, taken-branch flush and registered EX forwarding selects for the 5-stage pipe.
// Only the EX and MEM scoreboard slots feed a decision, so nothing older is kept.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int BR_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_is_load,
    input  logic              br_taken,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state
);

    localparam logic [1:0] LD_CNT = 2'(LOAD_LAT - 1);
    localparam logic [1:0] BR_CNT = 2'(BR_FLUSH - 1);

    hz_state_t          state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    sb_entry_t          e_q, e_d, m_q;
    logic [1:0]         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [1:0]         sel_a, sel_b;
    logic [SB_RD_W-1:0] rs_x, rt_x, rd_x;
    logic               hz, issue;

    assign rs_x = SB_RD_W'(id_rs);
    assign rt_x = SB_RD_W'(id_rt);
    assign rd_x = SB_RD_W'(id_rd);

    assign hz = id_valid && e_q.v && e_q.wr && e_q.ld && (e_q.rd != '0) &&
                ((id_use_rs && (rs_x == e_q.rd)) || (id_use_rt && (rt_x == e_q.rd)));

    fwd_select u_fwd_rs (.src_i(rs_x), .e_i(e_q), .m_i(m_q), .sel_o(sel_a));
    fwd_select u_fwd_rt (.src_i(rt_x), .e_i(e_q), .m_i(m_q), .sel_o(sel_b));

    // The first stall cycle is spent in RUN, so STALL covers the remaining LOAD_LAT-1 cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush     = 1'b0;
        case (state_q)
            RUN: begin
                if (br_taken) begin
                    state_d = FLUSH;
                    cnt_d   = BR_CNT;
                end else if (hz) begin
                    stall_if  = 1'b1;
                    bubble_ex = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = STALL;
                        cnt_d   = LD_CNT;
                    end
                end
            end
            STALL: begin
                if (br_taken) begin
                    state_d = FLUSH;
                    cnt_d   = BR_CNT;
                end else begin
                    stall_if  = id_valid;
                    bubble_ex = id_valid;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (br_taken) begin
                    cnt_d = BR_CNT;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // A taken branch squashes the ID instruction, so it never enters E.
    assign issue = id_valid && !stall_if && !flush && !br_taken;

    always_comb begin
        e_d     = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (issue) begin
            e_d.v   = 1'b1;
            e_d.wr  = id_wr;
            e_d.rd  = rd_x;
            e_d.ld  = id_is_load;
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            e_q     <= '0;
            m_q     <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            m_q     <= e_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
    assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3, both BR_FLUSH=2)
// share one instruction stream; each cycle's outputs are checked on the falling edge.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0, id_is_load = 1'b0;
    logic       br_taken = 1'b0;

    logic       s1_stall, s1_bub, s1_fl;
    logic [1:0] s1_fa, s1_fb, s1_st;
    logic       s3_stall, s3_bub, s3_fl;
    logic [1:0] s3_fa, s3_fb, s3_st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_FLUSH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
        .id_is_load(id_is_load), .br_taken(br_taken), .stall_if(s1_stall), .bubble_ex(s1_bub),
        .flush(s1_fl), .fwd_a(s1_fa), .fwd_b(s1_fb), .state(s1_st)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BR_FLUSH(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
        .id_is_load(id_is_load), .br_taken(br_taken), .stall_if(s3_stall), .bubble_ex(s3_bub),
        .flush(s3_fl), .fwd_a(s3_fa), .fwd_b(s3_fb), .state(s3_st)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // ID contents: valid, rs, rt, use_rs, use_rt, wr, rd, is_load
    task automatic id_set(input logic v, input int rs, input int rt, input logic urs,
                          input logic urt, input logic wr, input int rd, input logic ld);
        id_valid   = v;
        id_rs      = 5'(rs);
        id_rt      = 5'(rt);
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_wr      = wr;
        id_rd      = 5'(rd);
        id_is_load = ld;
    endtask

    task automatic id_none();
        id_set(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        mid();
        chk("rst_stall1", 32'(s1_stall), 0);
        chk("rst_flush1", 32'(s1_fl), 0);
        chk("rst_fwda1", 32'(s1_fa), 0);
        chk("rst_state3", 32'(s3_st), 0);
        nxt();
        rst_n = 1'b1;

        // ADD r9 <- r10,r11 ; SUB r12 <- r9,r1
        id_set(1'b1, 10, 11, 1'b1, 1'b1, 1'b1, 9, 1'b0);
        mid(); chk("add_stall", 32'(s1_stall), 0);
        nxt();
        id_set(1'b1, 9, 1, 1'b1, 1'b1, 1'b1, 12, 1'b0);
        mid(); chk("sub_stall1", 32'(s1_stall), 0); chk("sub_stall3", 32'(s3_stall), 0);
        chk("add_fwda", 32'(s1_fa), 0);
        nxt();
        id_none();
        mid(); chk("sub_fwda1", 32'(s1_fa), 1); chk("sub_fwdb1", 32'(s1_fb), 0);
        chk("sub_fwda3", 32'(s3_fa), 1); chk("sub_fwdb3", 32'(s3_fb), 0);
        nxt();

        // LW r9 ; ADD r12 <- r9,r9
        id_set(1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 9, 1'b1);
        mid(); chk("lw_stall", 32'(s1_stall), 0);
        nxt();
        id_set(1'b1, 9, 9, 1'b1, 1'b1, 1'b1, 12, 1'b0);
        mid(); chk("lu_stall1", 32'(s1_stall), 1); chk("lu_bub1", 32'(s1_bub), 1);
        chk("lu_stall3", 32'(s3_stall), 1); chk("lu_state1", 32'(s1_st), 0);
        nxt();
        mid(); chk("lu2_stall1", 32'(s1_stall), 0); chk("lu2_stall3", 32'(s3_stall), 1);
        chk("lu2_bub3", 32'(s3_bub), 1); chk("lu2_state3", 32'(s3_st), 1);
        nxt();
        mid(); chk("lu_fwda1", 32'(s1_fa), 2); chk("lu_fwdb1", 32'(s1_fb), 2);
        chk("lu3_stall3", 32'(s3_stall), 1); chk("lu3_state3", 32'(s3_st), 1);
        nxt();
        mid(); chk("lu4_stall3", 32'(s3_stall), 0); chk("lu4_state3", 32'(s3_st), 0);
        nxt();
        id_none();
        mid(); chk("lu_fwda3", 32'(s3_fa), 0); chk("lu_fwdb3", 32'(s3_fb), 0);
        nxt();

        // LW r5 ; ADD r12 <- r5,r6 with a taken branch in the same cycle
        id_set(1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1);
        nxt();
        id_set(1'b1, 5, 6, 1'b1, 1'b1, 1'b1, 12, 1'b0);
        br_taken = 1'b1;
        mid(); chk("br_stall1", 32'(s1_stall), 0); chk("br_stall3", 32'(s3_stall), 0);
        chk("br_bub1", 32'(s1_bub), 0); chk("br_flush0", 32'(s1_fl), 0);
        nxt();
        br_taken = 1'b0;
        mid(); chk("fl1_flush1", 32'(s1_fl), 1); chk("fl1_state1", 32'(s1_st), 2);
        chk("fl1_stall1", 32'(s1_stall), 0); chk("fl1_flush3", 32'(s3_fl), 1);
        nxt();
        mid(); chk("fl2_flush1", 32'(s1_fl), 1);
        nxt();
        mid(); chk("fl3_flush1", 32'(s1_fl), 0); chk("fl3_state1", 32'(s1_st), 0);
        chk("fl3_stall1", 32'(s1_stall), 0); chk("fl3_stall3", 32'(s3_stall), 0);
        nxt();

        // register 0: ADD r0 <- r1,r2 ; ADD r3 <- r0,r0 ; LW r0 ; ADD r3 <- r0,r0
        id_set(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        nxt();
        id_set(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        mid(); chk("r0_stall1", 32'(s1_stall), 0);
        nxt();
        id_set(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 0, 1'b1);
        mid(); chk("r0_fwda1", 32'(s1_fa), 0); chk("r0_fwdb1", 32'(s1_fb), 0);
        nxt();
        id_set(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        mid(); chk("r0ld_stall1", 32'(s1_stall), 0); chk("r0ld_stall3", 32'(s3_stall), 0);
        nxt();

        // reset asserted in the middle of a STALL cycle
        id_set(1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 7, 1'b1);
        nxt();
        id_set(1'b1, 7, 7, 1'b1, 1'b1, 1'b1, 8, 1'b0);
        mid(); chk("rs_stall3", 32'(s3_stall), 1);
        nxt();
        mid(); chk("rs_state3", 32'(s3_st), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_st_now", 32'(s3_st), 0); chk("rs_stall_now", 32'(s3_stall), 0);
        chk("rs_bub_now", 32'(s3_bub), 0); chk("rs_fl_now", 32'(s3_fl), 0);
        chk("rs_fwd_now", 32'({s3_fa, s3_fb, s1_fa, s1_fb}), 0);
        nxt();
        rst_n = 1'b1;
        mid(); chk("rs_after_stall3", 32'(s3_stall), 0); chk("rs_after_state3", 32'(s3_st), 0);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
